// File: rtl/spike_train_decoder.sv
// Decodes a T-bit spike train into spike count and time-to-first-spike; T+2 cycles from strobe to result.
// Results queue in a DEPTH-entry FIFO with valid/ready; strobes while not ready are dropped and flagged.
module spike_train_decoder #(
    parameter int T     = 16,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(T) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [T-1:0]  spike_in,
    input  logic          spike_valid,
    output logic          in_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [CW-1:0] out_count,
    output logic [CW-1:0] out_first,
    output logic          out_any,
    output logic          busy,
    output logic          drop_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int FW = PW + 1;

    typedef enum logic [1:0] {IDLE, SCAN, PUSH} state_t;

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic [CW-1:0] first;
    } res_t;

    state_t         state_q, state_d;
    logic [T-1:0]   shift_q, shift_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic [CW-1:0]  first_q, first_d;
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [FW-1:0]  fifo_cnt_q, fifo_cnt_d;
    logic           drop_q, drop_d;
    res_t           mem_q [DEPTH];
    res_t           mem_d [DEPTH];
    logic           push;
    logic           pop;
    res_t           head;

    assign in_ready  = (state_q == IDLE) && (fifo_cnt_q < FW'(DEPTH));
    assign out_valid = (fifo_cnt_q != '0);
    assign pop       = out_valid && out_ready;
    assign head      = mem_q[rd_ptr_q];
    assign out_count = out_valid ? head.cnt   : '0;
    assign out_first = out_valid ? head.first : '0;
    assign out_any   = (out_count != '0);
    assign busy      = (state_q != IDLE);
    assign drop_err  = drop_q;

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        first_d    = first_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        drop_d     = drop_q;
        mem_d      = mem_q;
        push       = 1'b0;

        if (spike_valid && !in_ready) begin
            drop_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (spike_valid && in_ready) begin
                    shift_d = spike_in;
                    cnt_d   = '0;
                    idx_d   = '0;
                    first_d = CW'(T);
                    state_d = SCAN;
                end
            end
            SCAN: begin
                if (shift_q[0]) begin
                    cnt_d = cnt_q + CW'(1);
                    if (first_q == CW'(T)) begin
                        first_d = idx_q;
                    end
                end
                shift_d = shift_q >> 1;
                idx_d   = idx_q + CW'(1);
                if (idx_q == CW'(T - 1)) begin
                    state_d = PUSH;
                end
            end
            PUSH: begin
                push            = 1'b1;
                mem_d[wr_ptr_q] = '{cnt: cnt_q, first: first_q};
                wr_ptr_d        = wr_ptr_q + PW'(1);
                state_d         = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // Simultaneous push and pop leaves the occupancy unchanged.
        case ({push, pop})
            2'b10:   fifo_cnt_d = fifo_cnt_q + FW'(1);
            2'b01:   fifo_cnt_d = fifo_cnt_q - FW'(1);
            default: fifo_cnt_d = fifo_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            idx_q      <= '0;
            first_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
            drop_q     <= 1'b0;
            mem_q      <= '{default: '0};
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            first_q    <= first_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt_q <= fifo_cnt_d;
            drop_q     <= drop_d;
            mem_q      <= mem_d;
        end
    end

endmodule
